// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types for the data-memory responder: FSM state enum,
//               posted-write buffer entry and array geometry constants.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_WORD_W      = 32;
    localparam int DMEM_DEPTH_WORDS = 256;
    localparam int DMEM_IDX_W       = $clog2(DMEM_DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        READ_RESP = 2'd2
    } dmem_state_e;

    // One posted store: word index into the array plus the data to write.
    typedef struct packed {
        logic [DMEM_IDX_W-1:0]  index;
        logic [DMEM_WORD_W-1:0] data;
    } dmem_wbuf_entry_t;

endpackage
`default_nettype wire

// File: rtl/dmem_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : dmem_wbuf
// Description : Circular posted-write FIFO with push/pop/count and a
//               combinational lookup that returns the newest entry whose
//               index matches the requested word index.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  dmem_wbuf_entry_t       push_entry_i,
    input  logic                   pop_i,
    output dmem_wbuf_entry_t       head_o,
    input  logic [DMEM_IDX_W-1:0]  lookup_idx_i,
    output logic                   lookup_hit_o,
    output logic [DMEM_WORD_W-1:0] lookup_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    dmem_wbuf_entry_t slots_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W-1:0] scan_ptr;

    // Pointers wrap naturally; the extra count bit separates full from empty.
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = slots_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; push together with pop keeps the count.
    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage is not reset; only occupied slots are ever consulted.
    always_ff @(negedge clk_i) begin
        if (push_i) begin
            slots_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Scan oldest to newest so the last match (the newest store) wins.
    always_comb begin
        lookup_hit_o  = 1'b0;
        lookup_data_o = '0;
        scan_ptr      = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_ptr = rd_ptr_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) && (slots_q[scan_ptr].index == lookup_idx_i)) begin
                lookup_hit_o  = 1'b1;
                lookup_data_o = slots_q[scan_ptr].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the pipeline MEM stage. Stores are
//               posted into a write buffer and drained in the background;
//               loads forward from the buffer or read the word array after
//               WAIT_STATES extra cycles. State updates on the falling edge.
//               Optional build macro: DMEM_ALIGN_CHECK_EN (misaligned-access
//               detection with addr_err / err_addr).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int WAIT_STATES = 2,
    parameter int WBUF_DEPTH  = 4
) (
    input  logic                        CLK,
    input  logic                        Reset,
    input  logic                        req_valid,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [31:0]                 req_wdata,
    output logic                        req_ready,
    output logic                        resp_valid,
    output logic [31:0]                 resp_rdata,
    output logic                        stall,
    output logic [$clog2(WBUF_DEPTH):0] wbuf_count,
    output logic                        addr_err,
    output logic [ADDR_W-1:0]           err_addr
);

    // The buffer entry index field follows the package depth; override both together.
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    logic [DMEM_WORD_W-1:0] mem_q [DEPTH_WORDS];

    dmem_state_e            state_q, state_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d, wait_cnt_dec;
    logic [IDX_W-1:0]       load_idx_q;
    logic [31:0]            rdata_q;

    logic [IDX_W-1:0]       req_idx;
    logic                   misaligned;
    logic                   accept;
    logic                   do_store;
    logic                   do_load;
    logic                   drain;
    logic                   wait_done;
    logic                   wb_full;
    logic                   wb_empty;
    logic                   wb_hit;
    logic [DMEM_WORD_W-1:0] wb_data;
    dmem_wbuf_entry_t       wb_head;
    dmem_wbuf_entry_t       wb_push_entry;

    assign req_idx = req_addr[IDX_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = |req_addr[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Stores need a free buffer slot; loads only need the FSM to be idle.
    assign req_ready     = (state_q == IDLE) && (req_write ? !wb_full : 1'b1);
    assign stall         = req_valid & ~req_ready;
    assign accept        = req_valid & req_ready;
    assign do_store      = accept & req_write & ~misaligned;
    assign do_load       = accept & ~req_write & ~misaligned;
    // Holding the drain during READ_WAIT keeps a miss from racing a store.
    assign drain         = (state_q != READ_WAIT) & ~wb_empty;
    assign resp_valid    = (state_q == READ_RESP);
    assign resp_rdata    = rdata_q;
    assign wait_cnt_dec  = wait_cnt_q - 1'b1;
    assign wait_done     = (wait_cnt_dec == '0);
    assign wb_push_entry = '{index: req_idx, data: req_wdata};

    dmem_wbuf #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk_i         (CLK),
        .rst_i         (Reset),
        .push_i        (do_store),
        .push_entry_i  (wb_push_entry),
        .pop_i         (drain),
        .head_o        (wb_head),
        .lookup_idx_i  (req_idx),
        .lookup_hit_o  (wb_hit),
        .lookup_data_o (wb_data),
        .count_o       (wbuf_count),
        .full_o        (wb_full),
        .empty_o       (wb_empty)
    );

    // Next-state logic: hits and zero-wait misses respond on the next cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (do_load) begin
                    if (wb_hit || (WAIT_STATES == 0)) begin
                        state_d = READ_RESP;
                    end else begin
                        state_d    = READ_WAIT;
                        wait_cnt_d = CNT_W'(WAIT_STATES);
                    end
                end
            end
            READ_WAIT: begin
                wait_cnt_d = wait_cnt_dec;
                if (wait_done) begin
                    state_d = READ_RESP;
                end
            end
            READ_RESP: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FSM state, wait counter and the index of the outstanding load.
    always_ff @(negedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            load_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (do_load) begin
                load_idx_q <= req_idx;
            end
        end
    end

    // Load data register: forwarded data, immediate array read, or delayed read.
    always_ff @(negedge CLK or posedge Reset) begin
        if (Reset) begin
            rdata_q <= '0;
        end else if (do_load && wb_hit) begin
            rdata_q <= wb_data;
        end else if (do_load && (WAIT_STATES == 0)) begin
            rdata_q <= mem_q[req_idx];
        end else if ((state_q == READ_WAIT) && wait_done) begin
            rdata_q <= mem_q[load_idx_q];
        end
    end

    // Background drain of the oldest posted store into the array.
    always_ff @(negedge CLK) begin
        if (drain) begin
            mem_q[wb_head.index] <= wb_head.data;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic              addr_err_q;
    logic [ADDR_W-1:0] err_addr_q;

    // One-cycle fault pulse; the faulting address is held until the next fault.
    always_ff @(negedge CLK or posedge Reset) begin
        if (Reset) begin
            addr_err_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            addr_err_q <= accept & misaligned;
            if (accept && misaligned) begin
                err_addr_q <= req_addr;
            end
        end
    end

    assign addr_err = addr_err_q;
    assign err_addr = err_addr_q;
`else
    assign addr_err = 1'b0;
    assign err_addr = '0;

    // Upper bits alias by design and the byte offset is ignored in this build.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder with a transaction-level
//               reference model (array + store queue + response countdown).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int ADDR_W      = 32;
    localparam int DEPTH_WORDS = 256;
    localparam int WAIT_STATES = 2;
    localparam int WBUF_DEPTH  = 4;
    localparam int IW          = 8;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        CLK;
    logic        Reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        stall;
    logic [2:0]  wbuf_count;
    logic        addr_err;
    logic [31:0] err_addr;

    dmem_responder #(
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .WAIT_STATES (WAIT_STATES),
        .WBUF_DEPTH  (WBUF_DEPTH)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .stall      (stall),
        .wbuf_count (wbuf_count),
        .addr_err   (addr_err),
        .err_addr   (err_addr)
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: array image, pending-store queue, response countdown.
    logic [31:0] mem_m [DEPTH_WORDS];
    int          q_idx [$];
    logic [31:0] q_dat [$];
    int          rem;
    logic [31:0] pend_data;
    bit          resp_now;
    logic [31:0] exp_rdata;
    bit          exp_err;
    logic [31:0] exp_err_addr;

    int idx_set [8] = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h04, 8'h01, 8'h02, 8'hFF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_ready(input bit w);
        return (rem == 0) && !resp_now && (!w || (q_idx.size() < WBUF_DEPTH));
    endfunction

    task automatic model_reset();
        q_idx.delete();
        q_dat.delete();
        rem          = 0;
        resp_now     = 1'b0;
        exp_rdata    = '0;
        pend_data    = '0;
        exp_err      = 1'b0;
        exp_err_addr = '0;
    endtask

    // One falling edge of the reference model.
    task automatic model_edge(input bit acc, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit          blocked;
        bit          mis;
        bit          hit;
        int          idx;
        logic [31:0] data;
        blocked  = (rem > 0);
        mis      = ALIGN_CHK && (a[1:0] != 2'b00);
        idx      = int'(a[IW+1:2]);
        resp_now = 1'b0;
        exp_err  = 1'b0;
        hit      = 1'b0;
        data     = '0;
        if (acc && mis) begin
            exp_err      = 1'b1;
            exp_err_addr = a;
        end else if (acc && !w) begin
            for (int i = q_idx.size() - 1; i >= 0; i--) begin
                if (!hit && (q_idx[i] == idx)) begin
                    hit  = 1'b1;
                    data = q_dat[i];
                end
            end
            if (!hit) data = mem_m[idx];
            pend_data = data;
            rem       = hit ? 1 : WAIT_STATES + 1;
        end
        if (!blocked && (q_idx.size() > 0)) begin
            mem_m[q_idx[0]] = q_dat[0];
            void'(q_idx.pop_front());
            void'(q_dat.pop_front());
        end
        if (acc && w && !mis) begin
            q_idx.push_back(idx);
            q_dat.push_back(d);
        end
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                resp_now  = 1'b1;
                exp_rdata = pend_data;
            end
        end
    endtask

    task automatic check_outputs();
        chk("resp_valid", 32'(resp_valid), 32'(resp_now));
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("wbuf_count", 32'(wbuf_count), 32'(q_idx.size()));
        chk("addr_err", 32'(addr_err), 32'(exp_err));
        chk("err_addr", err_addr, exp_err_addr);
    endtask

    // Drive one request slot starting just after the rising edge.
    task automatic cycle(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                         output bit acc);
        bit rdy;
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        #1;
        rdy = m_ready(w);
        chk("req_ready", 32'(req_ready), 32'(rdy));
        chk("stall", 32'(stall), 32'(v && !rdy));
        acc = v && rdy;
        @(negedge CLK);
        model_edge(acc, w, a, d);
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, acc);
    endtask

    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && (n < 20)) begin
            cycle(1'b1, w, a, d, acc);
            n++;
        end
        if (!acc) chk("req_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          acc;
        logic [31:0] a;
        Reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        check_outputs();
        Reset = 1'b0;

        // Give every address the bench will load a known value.
        foreach (idx_set[k]) do_req(1'b1, 32'(idx_set[k]) << 2, $urandom());
        idle(3);

        // Store then miss after drain.
        do_req(1'b1, 32'h0000_0040, 32'h1234_5678);
        idle(5);
        do_req(1'b0, 32'h0000_0040, 32'h0);
        idle(4);

        // Two stores to one word, immediate load forwards the newer value.
        do_req(1'b1, 32'h0000_0080, 32'hAAAA_0001);
        do_req(1'b1, 32'h0000_0080, 32'hBBBB_0002);
        do_req(1'b0, 32'h0000_0080, 32'h0);
        idle(3);

        // Stores interleaved with back-to-back loads to 0x100.
        do_req(1'b1, 32'h0000_0010, 32'hC0DE_0010);
        do_req(1'b1, 32'h0000_0200, 32'hC0DE_0200);
        do_req(1'b1, 32'h0000_0004, 32'hC0DE_0004);
        do_req(1'b1, 32'h0000_0008, 32'hC0DE_0008);
        do_req(1'b0, 32'h0000_0100, 32'h0);
        do_req(1'b0, 32'h0000_0100, 32'h0);
        do_req(1'b1, 32'h0000_03FC, 32'hC0DE_03FC);
        idle(4);

        // Upper address bits alias onto the same word.
        do_req(1'b0, 32'hFFFF_F040, 32'h0);
        idle(3);

        // Misaligned load: error pulse with the check enabled, word 0x40 otherwise.
        do_req(1'b0, 32'h0000_0042, 32'h0);
        idle(4);

        // Reset while a miss is waiting: outstanding load is dropped.
        do_req(1'b0, 32'h0000_0200, 32'h0);
        Reset = 1'b1;
        #1;
        model_reset();
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        check_outputs();
        @(negedge CLK);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        idle(6);

        // Randomized traffic over the initialized word set.
        for (int n = 0; n < 400; n++) begin
            a = ($urandom() & 32'hFFFF_FC00) | (32'(idx_set[$urandom_range(0, 7)]) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom(), acc);
        end
        req_valid = 1'b0;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
